// File: rtl/pro_ctrl.sv
// Multi-cycle control unit for the 8-LED demo processor: fetch, decode, and strobe sequencing.
// Define PRO_CTRL_JUMP_EN to build JMP/JZ and the zero flag; without it opcodes 9/A retire as NOP.
module pro_ctrl #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] instr_addr,
  output logic            instr_req,
  input  logic            instr_ack,
  input  logic [15:0]     instr_rdata,
  output logic [3:0]      rf_raddr_a,
  output logic [3:0]      rf_raddr_b,
  output logic [3:0]      rf_waddr,
  output logic            rf_we,
  output logic [1:0]      rf_wsel,
  output logic [7:0]      imm,
  output logic [1:0]      alu_op,
  input  logic            alu_zero,
  output logic [PC_W-1:0] dmem_addr,
  output logic            dmem_re,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            led_we,
  output logic            halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_LD  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next, pc_inc;
  logic [15:0]     ir;
  logic [3:0]      opcode;
  logic            is_alu;

  assign opcode = ir[15:12];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_OR);
  assign pc_inc = pc + PC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH && instr_ack) ir <= instr_rdata;
    end
  end

`ifdef PRO_CTRL_JUMP_EN
  logic zero_flag, zero_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_flag <= 1'b0;
    else     zero_flag <= zero_next;
  end
`else
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    rf_we      = 1'b0;
    rf_wsel    = 2'b00;
    led_we     = 1'b0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
`ifdef PRO_CTRL_JUMP_EN
    zero_next  = zero_flag;
`endif
    case (state)
      FETCH: begin
        if (instr_ack) state_next = DECODE;
      end
      DECODE: begin
        if (opcode == OP_LD || opcode == OP_ST) state_next = MEM;
        else if (opcode == OP_HLT)              state_next = HALT;
        else                                    state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        pc_next    = pc_inc;
        if (is_alu) begin
          rf_we = 1'b1;
`ifdef PRO_CTRL_JUMP_EN
          zero_next = alu_zero;
`endif
        end else if (opcode == OP_LDI) begin
          rf_we   = 1'b1;
          rf_wsel = 2'b01;
        end else if (opcode == OP_OUT) begin
          led_we = 1'b1;
        end
`ifdef PRO_CTRL_JUMP_EN
        if (opcode == OP_JMP || (opcode == OP_JZ && zero_flag))
          pc_next = PC_W'(ir[7:0]);
`endif
      end
      MEM: begin
        dmem_re = (opcode == OP_LD);
        dmem_we = (opcode == OP_ST);
        if (opcode == OP_LD) rf_wsel = 2'b10;
        // Load write-back rides the ack cycle itself: the only input-to-strobe path.
        if (dmem_ack) begin
          rf_we      = (opcode == OP_LD);
          pc_next    = pc_inc;
          state_next = FETCH;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Request is masked by rst so it drops the instant reset is applied.
  assign instr_req  = (state == FETCH) && !rst;
  assign instr_addr = pc;
  assign rf_raddr_a = ir[11:8];
  assign rf_raddr_b = ir[7:4];
  assign rf_waddr   = ir[11:8];
  assign imm        = ir[7:0];
  assign alu_op     = 2'(opcode - 4'd2);
  assign dmem_addr  = PC_W'(ir[7:0]);
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_pro_ctrl.sv
// Bench for pro_ctrl: table of instructions with expected strobes/cycles, fetch-address scoreboard,
// plus hand sequences for PC wrap, halt hold and asynchronous reset during FETCH and MEM.
module tb_pro_ctrl;

  logic        clk, rst;
  logic [7:0]  instr_addr, dmem_addr, imm;
  logic        instr_req, instr_ack, rf_we, dmem_re, dmem_we, dmem_ack, led_we, halted, alu_zero;
  logic [15:0] instr_rdata;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [1:0]  rf_wsel, alu_op;

  pro_ctrl #(.PC_W(8)) dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(instr_ack), .instr_rdata(instr_rdata),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr), .rf_we(rf_we),
    .rf_wsel(rf_wsel), .imm(imm), .alu_op(alu_op), .alu_zero(alu_zero),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .led_we(led_we), .halted(halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst_first;
    logic [15:0] instr;
    int          ack_wait;
    int          dmem_wait;
    logic        zero_in;
    logic        taken;
    int          exp_cycles;
    logic        exp_we;
    logic [1:0]  exp_wsel;
    logic [1:0]  exp_aluop;
    logic        exp_led;
    int          exp_re;
    int          exp_wr;
    logic        exp_halt;
  } vec_t;

  vec_t       vecs[19];
  logic [7:0] exp_q[$];
  logic [7:0] exp_pc;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    int bad;
    bad = 0;
    @(negedge clk);
    rst = 1'b1; instr_ack = 1'b0; dmem_ack = 1'b0; instr_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      if (instr_req || rf_we || led_we || dmem_re || dmem_we || halted) bad++;
    end
    chk("reset_quiet", bad, 0);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_pc = 8'h00;
    #1 chk("first_req", instr_req, 1);
  endtask

  // driver + monitor for one instruction, starting at a negedge inside FETCH
  task automatic run_vec(input vec_t v);
    logic [7:0] exp_addr, nxt;
    logic       ok, taken_eff, we_ack, saw_halt;
    logic [1:0] wsel_s, aluop_s;
    logic [3:0] waddr_s, rb_s, led_ra;
    logic [7:0] imm_s;
    int         c, held, n_we, we_cyc, n_led, led_cyc, n_re, n_wr, mc, overlap, bad_addr;
    c = 0; held = 0; n_we = 0; we_cyc = 0; n_led = 0; led_cyc = 0; n_re = 0; n_wr = 0;
    mc = 0; overlap = 0; bad_addr = 0; we_ack = 0; saw_halt = 0;
    wsel_s = '0; aluop_s = '0; waddr_s = '0; rb_s = '0; led_ra = '0; imm_s = '0;
    if (v.rst_first) do_reset();
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (instr_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("req_seen", ok, 1);
    if (!ok) return;
    exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    chk("fetch_addr", instr_addr, exp_addr);
    for (int w = 0; w <= v.ack_wait; w++) begin
      if (w > 0) @(negedge clk);
      c++;
      if (instr_req && instr_addr == exp_addr) held++;
      alu_zero    = v.zero_in;
      dmem_ack    = 1'($urandom_range(0, 1));
      instr_ack   = (w == v.ack_wait);
      instr_rdata = instr_ack ? v.instr : 16'($urandom);
    end
    if (v.instr[15:12] != 4'hF) begin
      taken_eff = 1'b0;
`ifdef PRO_CTRL_JUMP_EN
      taken_eff = v.taken;
`endif
      nxt = taken_eff ? v.instr[7:0] : exp_pc + 8'd1;
      exp_q.push_back(nxt);
      exp_pc = nxt;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (instr_req) begin instr_ack = 1'b0; break; end
      instr_ack   = 1'($urandom_range(0, 1));
      instr_rdata = 16'($urandom);
      c++;
      if (dmem_re || dmem_we) begin
        mc++;
        dmem_ack = (mc == v.dmem_wait + 1);
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      if (rf_we) begin
        n_we++; we_cyc = c; wsel_s = rf_wsel; aluop_s = alu_op; waddr_s = rf_waddr;
        rb_s = rf_raddr_b; imm_s = imm; we_ack = dmem_ack;
      end
      if (led_we) begin n_led++; led_cyc = c; led_ra = rf_raddr_a; end
      if (rf_we && led_we) overlap++;
      if (dmem_re) n_re++;
      if (dmem_we) n_wr++;
      if ((dmem_re || dmem_we) && dmem_addr != v.instr[7:0]) bad_addr++;
      if (halted) begin saw_halt = 1'b1; break; end
    end
    dmem_ack = 1'b0;
    instr_ack = 1'b0;
    chk("req_held", held, v.ack_wait + 1);
    chk("cycles", c, v.exp_cycles);
    chk("rf_we_count", n_we, 32'(v.exp_we));
    if (v.exp_we) begin
      chk("rf_we_cycle", we_cyc, c);
      chk("rf_waddr", waddr_s, v.instr[11:8]);
      chk("rf_wsel", wsel_s, v.exp_wsel);
      if (v.exp_wsel == 2'b01) chk("imm", imm_s, v.instr[7:0]);
      if (v.exp_wsel == 2'b00) begin
        chk("alu_op", aluop_s, v.exp_aluop);
        chk("rf_raddr_b", rb_s, v.instr[7:4]);
      end
      if (v.exp_wsel == 2'b10) chk("ld_we_with_ack", we_ack, 1);
    end
    chk("led_we_count", n_led, 32'(v.exp_led));
    if (v.exp_led) begin
      chk("led_we_cycle", led_cyc, c);
      chk("led_raddr_a", led_ra, v.instr[11:8]);
    end
    chk("dmem_re_cycles", n_re, v.exp_re);
    chk("dmem_we_cycles", n_wr, v.exp_wr);
    chk("dmem_addr", bad_addr, 0);
    chk("we_led_overlap", overlap, 0);
    chk("halted", saw_halt, v.exp_halt);
  endtask

  initial begin
    vec_t v;
    int   bad, guard;
    logic ok;
    rst = 1'b1; instr_ack = 1'b0; dmem_ack = 1'b0; instr_rdata = '0; alu_zero = 1'b0;
    exp_pc = '0;

    // rst_first instr aw dw z tk cyc we wsel aluop led re wr halt
    vecs[0]  = '{1'b1, 16'h115A, 0, 0, 1'b0, 1'b0, 3, 1'b1, 2'b01, 2'b00, 1'b0, 0, 0, 1'b0};
    vecs[1]  = '{1'b0, 16'h8100, 0, 0, 1'b0, 1'b0, 3, 1'b0, 2'b00, 2'b00, 1'b1, 0, 0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0000, 4, 0, 1'b0, 1'b0, 7, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0};
    vecs[3]  = '{1'b0, 16'h3220, 0, 0, 1'b1, 1'b0, 3, 1'b1, 2'b00, 2'b01, 1'b0, 0, 0, 1'b0};
    vecs[4]  = '{1'b0, 16'hA040, 0, 0, 1'b0, 1'b1, 3, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0};
    vecs[5]  = '{1'b0, 16'h3220, 0, 0, 1'b0, 1'b0, 3, 1'b1, 2'b00, 2'b01, 1'b0, 0, 0, 1'b0};
    vecs[6]  = '{1'b0, 16'hA040, 1, 0, 1'b1, 1'b0, 4, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0};
    vecs[7]  = '{1'b0, 16'h2450, 2, 0, 1'b0, 1'b0, 5, 1'b1, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0};
    vecs[8]  = '{1'b0, 16'h4120, 0, 0, 1'b0, 1'b0, 3, 1'b1, 2'b00, 2'b10, 1'b0, 0, 0, 1'b0};
    vecs[9]  = '{1'b0, 16'h5120, 0, 0, 1'b1, 1'b0, 3, 1'b1, 2'b00, 2'b11, 1'b0, 0, 0, 1'b0};
    vecs[10] = '{1'b0, 16'h1600, 0, 0, 1'b0, 1'b0, 3, 1'b1, 2'b01, 2'b00, 1'b0, 0, 0, 1'b0};
    vecs[11] = '{1'b0, 16'h6310, 0, 2, 1'b0, 1'b0, 5, 1'b1, 2'b10, 2'b00, 1'b0, 3, 0, 1'b0};
    vecs[12] = '{1'b0, 16'h8300, 0, 0, 1'b0, 1'b0, 3, 1'b0, 2'b00, 2'b00, 1'b1, 0, 0, 1'b0};
    vecs[13] = '{1'b0, 16'hA030, 0, 0, 1'b0, 1'b1, 3, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0};
    vecs[14] = '{1'b0, 16'h7322, 0, 1, 1'b0, 1'b0, 4, 1'b0, 2'b00, 2'b00, 1'b0, 0, 2, 1'b0};
    vecs[15] = '{1'b0, 16'h6720, 0, 0, 1'b0, 1'b0, 3, 1'b1, 2'b10, 2'b00, 1'b0, 1, 0, 1'b0};
    vecs[16] = '{1'b0, 16'hB123, 0, 0, 1'b1, 1'b0, 3, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0};
    vecs[17] = '{1'b0, 16'hE000, 1, 0, 1'b0, 1'b0, 4, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0};
    vecs[18] = '{1'b0, 16'h90FD, 0, 0, 1'b0, 1'b1, 3, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0};

    for (int i = 0; i < 19; i++) run_vec(vecs[i]);

    // walk the PC up to 0xFF with NOPs, then one more NOP must wrap to 0x00
    guard = 0;
    while (exp_pc != 8'hFF && guard < 300) begin
      v = '{1'b0, 16'h0000, 0, 0, 1'b0, 1'b0, 3, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0};
      v.ack_wait   = $urandom_range(0, 1);
      v.exp_cycles = v.ack_wait + 3;
      run_vec(v);
      guard++;
    end
    v = '{1'b0, 16'h0C00, 0, 0, 1'b0, 1'b0, 3, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 1'b0};
    run_vec(v);

    // HLT fetched from 0x00 after the wrap, then must stay halted
    v = '{1'b0, 16'hF000, 0, 0, 1'b0, 1'b0, 3, 1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 1'b1};
    run_vec(v);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      instr_ack = 1'($urandom_range(0, 1));
      dmem_ack  = 1'($urandom_range(0, 1));
      instr_rdata = 16'($urandom);
      #1;
      if (!halted || instr_req || rf_we || led_we || dmem_re || dmem_we) bad++;
    end
    instr_ack = 1'b0; dmem_ack = 1'b0;
    chk("halt_hold", bad, 0);

    // reset asserted mid-FETCH drops the request at once
    do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_drops_req", instr_req, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); exp_q.push_back(8'h00); exp_pc = 8'h00;
    v = vecs[0]; v.rst_first = 1'b0;
    run_vec(v);
    run_vec(vecs[1]);

    // reset asserted mid-ST drops dmem_we at once; restart fetches from 0
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (instr_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("st_req_seen", ok, 1);
    chk("st_fetch_addr", instr_addr, exp_q.size() > 0 ? exp_q.pop_front() : 8'h00);
    instr_ack = 1'b1; instr_rdata = 16'h7133;
    @(negedge clk);
    instr_ack = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (dmem_we) begin ok = 1'b1; break; end
    end
    chk("st_dmem_we_seen", ok, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drops_dmem_we", dmem_we, 0);
    chk("rst_no_rf_we", rf_we, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("restart_addr", instr_addr, 8'h00);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (dmem_we || dmem_re || rf_we || !instr_req) bad++;
    end
    chk("no_write_after_rst", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pro_ctrl.md
# pro_ctrl

Multi-cycle control unit for the 8-LED demo processor `pro`. It fetches 16-bit instructions over a request/acknowledge port, decodes them, and sequences the register file, ALU, data memory and LED output register through a fixed state machine. It owns the program counter and the zero flag and drives every datapath strobe; the datapath itself holds no control state.

## Interface
- `PC_W`, 8, program-counter and data-address width
- `clk`  in  1  system clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `instr_addr`  out  PC_W  fetch address (equals PC)
- `instr_req`  out  1  fetch request
- `instr_ack`  in  1  fetch done; `instr_rdata` valid this cycle
- `instr_rdata`  in  16  instruction word
- `rf_raddr_a`  out  4  read port A = IR[11:8] (rd)
- `rf_raddr_b`  out  4  read port B = IR[7:4] (rs)
- `rf_waddr`  out  4  write address = IR[11:8]
- `rf_we`  out  1  register write strobe
- `rf_wsel`  out  2  write source: 00 ALU, 01 immediate, 10 data memory
- `imm`  out  8  IR[7:0]
- `alu_op`  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
- `alu_zero`  in  1  ALU result is zero
- `dmem_addr`  out  PC_W  IR[7:0]
- `dmem_re`, `dmem_we`  out  1  data read/write request
- `dmem_ack`  in  1  data access done (read data valid this cycle)
- `led_we`  out  1  load LED register from read port A
- `halted`  out  1  core stopped

## Operation
- Opcodes, IR[15:12]: 0 NOP; 1 LDI rd,imm; 2 ADD; 3 SUB; 4 AND; 5 OR (rd ← rd op rs); 6 LD rd,[imm]; 7 ST rd,[imm]; 8 OUT rd; 9 JMP imm; A JZ imm; F HLT; B–E execute as NOP.
- States: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH: `instr_req`=1 with `instr_addr`=PC. It holds until `instr_ack`. On ack, latch IR and go to DECODE.
- DECODE: one cycle with no strobes. Go to MEM for LD/ST, HALT for HLT, otherwise EXEC.
- EXEC: single cycle.
  - ALU ops: `rf_we`=1, `rf_wsel`=00, zero flag ← `alu_zero`.
  - LDI: `rf_we`=1, `rf_wsel`=01.
  - OUT: `led_we`=1.
  - JMP: PC ← imm.
  - JZ: PC ← imm if zero flag=1, else PC+1.
  - All other instructions: PC ← PC+1.
  - Next state is FETCH.
- MEM: `dmem_re` (LD) or `dmem_we` (ST) is held until `dmem_ack`.
  - In the ack cycle of an LD: `rf_we`=1, `rf_wsel`=10 (combinational from ack).
  - On ack: PC ← PC+1, go to FETCH.
- HALT: `halted`=1, no strobes. The only exit is reset.
- Zero flag changes only on ALU ops. LDI, LD and OUT leave it unchanged.
- PC arithmetic is modulo 2^PC_W: 0xFF+1 → 0x00. Jump targets are zero-extended imm.
- Acks outside their requesting state are ignored.
- Strobes decode from the state and IR registers. The only input-to-output path is `dmem_ack` → `rf_we`.

## Timing
- Reset values: state=FETCH, PC=0, IR=0, zero flag=0. All strobes 0, `halted`=0, `instr_req` 0 while `rst` is high.
- The first `instr_req` is asserted in the first cycle after `rst` falls.
- With zero-wait acks:
  - NOP, LDI, ALU, OUT, JMP, JZ: 3 cycles.
  - LD/ST: 3 cycles.
  - Each wait cycle adds one cycle.
- Every strobe is exactly one cycle wide, except held requests.
- `rst` asserted mid-MEM or mid-FETCH drops the request immediately (asynchronous) and discards IR. No partial write occurs after reset.
- `rf_we` and `led_we` are never asserted in the same cycle.

## Configuration
- `PRO_CTRL_JUMP_EN` defined: JMP and JZ behave as above.
- `PRO_CTRL_JUMP_EN` undefined:
  - Opcodes 9 and A execute as NOP (PC+1).
  - The zero flag register and the `alu_zero` input logic are removed; the port remains and is unused.

## Test plan
- Reset, then program LDI r1,0x5A; OUT r1 with zero-wait acks:
  - `instr_addr` 0, then 1.
  - `rf_we` in cycle 3 with `rf_wsel`=01 and `imm`=0x5A.
  - `led_we` in cycle 6.
- `instr_ack` delayed 4 cycles on the first fetch → `instr_req` held 5 cycles with `instr_addr`=0. Instruction completes in 7 cycles.
- SUB r2,r2 with `alu_zero`=1, then JZ 0x40 → next `instr_addr`=0x40. With `alu_zero`=0 → next `instr_addr`=PC+1. Without the macro → always PC+1.
- LD r3,[0x10] with `dmem_ack` after 2 waits:
  - `dmem_re` high 3 cycles, `dmem_addr`=0x10.
  - `rf_we`=1 with `rf_wsel`=10 only in the ack cycle.
- PC at 0xFF executing NOP → next fetch at 0x00.
- HLT → `halted`=1 and `instr_req`=0 indefinitely. `rst` pulsed mid-ST (with `dmem_we` high) → `dmem_we` drops asynchronously and the next fetch is from 0x00.
